// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage load/store unit and memory.
// The unit drives the request side (master); memory returns rdata/ack (slave).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [3:0]            bus_be;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack bus access with lane steering and load extension.
// Define LSU_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES un-acked BUSY cycles.
//
// state | meaning
// IDLE  | waiting for a valid, aligned load/store
// BUSY  | bus_req held, waiting for bus_ack (or timeout)
// DONE  | one-cycle completion, pipeline released
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  memwrite,
  input  logic                  memtoreg,
  input  logic [1:0]            swhb,
  input  logic [1:0]            lwhb,
  input  logic                  lunsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  mem_access_unit_if.master     bus,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           rdata,
  output logic                  misalign,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} acc_size_t;

  state_t     state;
  acc_size_t  acc_size;
  acc_size_t  ld_size;
  logic       ld_unsigned;
  logic [1:0] ld_off;
  logic       access;
  logic       mis;
  logic       start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  // A store wins when memwrite and memtoreg are both set.
  always_comb begin
    acc_size = SZ_WORD;
    if (memwrite) begin
      case (swhb)
        2'b10:   acc_size = SZ_HALF;
        2'b11:   acc_size = SZ_BYTE;
        default: acc_size = SZ_WORD;
      endcase
    end else begin
      case (lwhb)
        2'b01:   acc_size = SZ_HALF;
        2'b10:   acc_size = SZ_BYTE;
        default: acc_size = SZ_WORD;
      endcase
    end
  end

  always_comb begin
    mis        = 1'b0;
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (acc_size)
      SZ_HALF: begin
        mis        = addr[0];
        be_next    = 4'b0011 << addr[1:0];
        wdata_next = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      default: begin
        mis = (addr[1:0] != 2'b00);
      end
    endcase
  end

  assign access   = valid & (memwrite | memtoreg);
  assign start    = access & ~mis & (state == IDLE);
  assign misalign = access & mis & (state == IDLE);
  assign stall    = start | (state == BUSY);

  always_comb begin
    shifted = bus.bus_rdata >> {ld_off, 3'b000};
    case (ld_size)
      SZ_HALF: ld_data = ld_unsigned ? {16'h0000, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      SZ_BYTE: ld_data = ld_unsigned ? {24'h000000, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      default: ld_data = bus.bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'h0;
      rdata         <= 32'h0;
      done          <= 1'b0;
      ld_size       <= SZ_WORD;
      ld_unsigned   <= 1'b0;
      ld_off        <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt           <= '0;
      bus_err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= memwrite;
            bus.bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            bus.bus_be    <= be_next;
            bus.bus_wdata <= wdata_next;
            ld_size       <= acc_size;
            ld_unsigned   <= lunsigned;
            ld_off        <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt           <= '0;
`endif
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) rdata <= ld_data;
            done        <= 1'b1;
            state       <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
